serial_adder: RTL and testbench

Bit-serial W-bit adder built around the existing one-bit `full_adder` cell. It accepts two parallel operands and a carry-in over a valid/ready handshake, then feeds the cell one bit per clock, LSB first, holding the carry in a flip-flop between bits. It presents the parallel sum and carry-out over a valid/ready output handshake. It sits directly downstream of operand sources and consumes every sum/carry the `full_adder` cell produces.

---
 rtl/serial_adder_pkg.sv | 6 +
 rtl/full_adder.sv | 11 +
 rtl/serial_adder.sv | 75 +++++++
 tb/tb_serial_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and width limits shared by the serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {SA_IDLE, SA_RUN, SA_DONE} sa_state_t;
  localparam int SA_W_DEFAULT = 8;
  localparam int SA_W_MAX = 32;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial W-bit adder with valid/ready in/out handshakes, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = SA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int CW = $clog2(W) + 1;
  sa_state_t state;
  logic [W-1:0] a_sh, b_sh, sum_sh;
  logic c_q, fa_s, fa_c;
  logic [CW-1:0] cnt;
  full_adder u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(c_q), .s(fa_s), .co(fa_c));
  assign in_ready = state == SA_IDLE;
  assign busy = state == SA_RUN;
  assign out_valid = state == SA_DONE;
  assign sum = sum_sh;
  assign cout = c_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SA_IDLE;
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      c_q <= 1'b0;
      cnt <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      case (state)
        SA_IDLE: if (in_valid) begin
          a_sh <= a;
          b_sh <= b;
          c_q <= cin;
          cnt <= '0;
          state <= SA_RUN;
        end
        SA_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          sum_sh <= W'({fa_s, sum_sh} >> 1);
          c_q <= fa_c;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state <= SA_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q is the carry into the MSB, fa_c the carry out of it
            ovf <= c_q ^ fa_c;
`endif
          end
        end
        SA_DONE: if (out_ready) state <= SA_IDLE;
        default: state <= SA_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus handshake corner cases for serial_adder (W=8 and W=2).
module tb_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv8 = 1'b0, ir8, c8 = 1'b0, ov8, or8 = 1'b0, co8, bz8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic iv2 = 1'b0, ir2, c2 = 1'b0, ov2, or2 = 1'b0, co2, bz2;
  logic [1:0] a2 = '0, b2 = '0, s2;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf2;
`endif
  serial_adder #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_adder #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(c2),
    .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .busy(bz2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic ordy, output int lat);
    a8 = a; b8 = b; c8 = c; iv8 = 1'b1; or8 = ordy;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!ov8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;
  vec_t vecs[7];
  initial begin
    int lat, n;
    logic got;
    logic [2:0] e;
    logic [4:0] v;
    int sv;
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(ir8), 1);
    chk("rst_out_valid", 32'(ov8), 0);
    chk("rst_busy", 32'(bz8), 0);
    chk("rst_sum", 32'(s8), 0);
    chk("rst_cout", 32'(co8), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 8);
      chk($sformatf("v%0d_sum", i), 32'(s8), 32'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 32'(co8), 32'(vecs[i].cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(ovf8), 32'(vecs[i].ovf));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), 32'({ir8, ov8}), 32'b10);
    end
    op8(8'h12, 8'h34, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 8);
    a8 = 8'hFF; b8 = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      chk("bp_sum", 32'(s8), 32'h46);
      chk("bp_hold", 32'({ov8, ir8, co8}), 32'b100);
      iv8 = k[0] ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'({ov8, ir8, bz8}), 32'b010);
    chk("bp_sum_after", 32'(s8), 32'h46);
    @(negedge clk);
    chk("bp_single_hs", 32'({ov8, ir8, bz8}), 32'b010);
    a8 = 8'h55; b8 = 8'h22; c8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(bz8), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_state", 32'({ir8, ov8, bz8}), 32'b100);
    chk("mid_rst_sum", 32'({co8, s8}), 0);
    op8(8'h01, 8'h01, 1'b0, 1'b1, lat);
    chk("post_rst_sum", 32'({co8, s8}), 32'h002);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      v = i[4:0];
      a2 = v[4:3]; b2 = v[2:1]; c2 = v[0]; iv2 = 1'b1; or2 = 1'b1;
      @(posedge clk);
      #1;
      e = 3'(a2) + 3'(b2) + 3'(c2);
      sv = int'($signed(a2)) + int'($signed(b2)) + int'(c2);
      n = 0; got = 1'b0;
      while (1) begin
        @(negedge clk);
        if (i == 0 && n == 0) chk("w2_busy", 32'(bz2), 1);
        if (ov2) begin
          chk($sformatf("w2_sum_%0d", i), 32'({co2, s2}), 32'(e));
`ifdef SERIAL_ADDER_OVF_EN
          chk($sformatf("w2_ovf_%0d", i), 32'(ovf2), 32'(sv > 1 || sv < -2));
`endif
          got = 1'b1;
        end
        if (ir2 || n >= 20) break;
        n++;
      end
      chk($sformatf("w2_result_seen_%0d", i), 32'(got), 1);
      chk($sformatf("w2_spacing_%0d", i), 32'(n + 1), 4);
    end
    iv2 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
